uart_rx_frame_parser: RTL

- Drains the UART receive FIFO (8-bit, first-word-fall-through off) and parses framed packets: SOF, LEN, payload, CHK.
- Forwards payload bytes on a valid/ready stream and reports per-frame status.
- Sits between the UART Rx + FIFO block and the command decoder.
- Owns the FIFO read port exclusively: it issues every pop and decides when popping is allowed.

---
 rtl/uart_rx_frame_parser.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: drains the Rx FIFO, parses SOF/LEN/payload/CHK frames,
// streams payload bytes on valid/ready and reports per-frame status.
module uart_rx_frame_parser #(
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         MAX_LEN     = 64,
  parameter int         TIMEOUT_CYC = 48_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fifo_empty,
  input  logic [7:0]  i_fifo_dout,
  output logic        o_fifo_rd_en,
  output logic [7:0]  o_m_data,
  output logic        o_m_valid,
  input  logic        i_m_ready,
  output logic        o_m_last,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_err_cnt
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;
  state_t        r_state, w_state_nx;
  logic          r_rd_en, r_pend, r_valid, r_last, r_done, r_ok;
  logic [7:0]    r_data, r_sum;
  logic [1:0]    r_err, w_err;
  logic [15:0]   r_err_cnt;
  logic [LW-1:0] r_len_rem;
  logic [TW-1:0] r_to_cnt;
  logic          w_sample, w_stall, w_timeout, w_pop, w_len_bad, w_end, w_load;

  // r_pend marks the cycle in which the popped byte is on i_fifo_dout
  assign w_sample  = r_pend;
  assign w_stall   = r_valid & ~i_m_ready;
  assign w_timeout = (r_state != HUNT) & ~w_sample & (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_pop     = ~i_fifo_empty & ~r_rd_en & ~r_pend & ((r_state != PAYLOAD) | ~w_stall);
  assign w_len_bad = (i_fifo_dout == 8'd0) | (32'(i_fifo_dout) > MAX_LEN);
  assign w_load    = w_sample & (r_state == PAYLOAD);

  always_comb begin
    w_state_nx = r_state;
    w_end = 1'b0;
    w_err = 2'd0;
    if (w_timeout) begin
      w_state_nx = HUNT;
      w_end = 1'b1;
      w_err = 2'd3;
    end else if (w_sample) begin
      case (r_state)
        HUNT:    w_state_nx = (i_fifo_dout == SOF_BYTE) ? LEN : HUNT;
        LEN: begin
          w_state_nx = w_len_bad ? HUNT : PAYLOAD;
          w_end = w_len_bad;
          w_err = w_len_bad ? 2'd1 : 2'd0;
        end
        PAYLOAD: w_state_nx = (r_len_rem == LW'(1)) ? CHK : PAYLOAD;
        default: begin
          w_state_nx = HUNT;
          w_end = 1'b1;
          w_err = (i_fifo_dout == r_sum) ? 2'd0 : 2'd2;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= HUNT;
    else r_state <= w_state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_en   <= 1'b0;
      r_pend    <= 1'b0;
      r_to_cnt  <= '0;
      r_len_rem <= '0;
      r_sum     <= 8'd0;
      r_valid   <= 1'b0;
      r_data    <= 8'd0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_err     <= 2'd0;
      r_err_cnt <= 16'd0;
    end else begin
      r_rd_en  <= w_pop;
      r_pend   <= r_rd_en;
      // backpressure freezes the inter-byte timer
      r_to_cnt <= (r_state == HUNT || w_sample || w_timeout) ? '0 : w_stall ? r_to_cnt : r_to_cnt + 1'b1;
      if (w_sample && r_state == LEN) begin
        r_len_rem <= LW'(i_fifo_dout);
        r_sum     <= i_fifo_dout;
      end
      if (w_load) begin
        r_len_rem <= r_len_rem - 1'b1;
        r_sum     <= r_sum + i_fifo_dout;
      end
      r_valid <= w_load | w_stall;
      if (w_load) begin
        r_data <= i_fifo_dout;
        r_last <= (r_len_rem == LW'(1));
      end else if (w_timeout) r_last <= 1'b0;
      r_done <= w_end;
      if (w_end) begin
        r_ok  <= (w_err == 2'd0);
        r_err <= w_err;
      end
      if (w_end && w_err != 2'd0 && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_fifo_rd_en = r_rd_en;
  assign o_m_data     = r_data;
  assign o_m_valid    = r_valid;
  assign o_m_last     = r_last;
  assign o_frame_done = r_done;
  assign o_frame_ok   = r_ok;
  assign o_err_code   = r_err;
  assign o_err_cnt    = r_err_cnt;
endmodule
